// File: rtl/processador_pkg.sv
// Shared types and encodings for the multi-cycle control unit and its opcode decoder.
package processador_pkg;

    typedef enum logic [4:0] {
        OP_NOP  = 5'b00000,
        OP_MOV  = 5'b00001,
        OP_ADD  = 5'b00010,
        OP_SUB  = 5'b00011,
        OP_MUL  = 5'b00100,
        OP_DIV  = 5'b00101,
        OP_AND  = 5'b00110,
        OP_OR   = 5'b00111,
        OP_NEG  = 5'b01000,
        OP_ADDI = 5'b01001,
        OP_SUBI = 5'b01010,
        OP_BLT  = 5'b01011,
        OP_BGT  = 5'b01100,
        OP_JMP  = 5'b01101,
        OP_HALT = 5'b11111
    } opcode_t;

    typedef enum logic [2:0] {
        FETCH,
        DECODE,
        EXECUTE,
        WRITEBACK,
        BRANCH,
        HALT
    } estado_t;

    typedef enum logic [2:0] {
        CL_NOP,
        CL_ALU,
        CL_CMP,
        CL_JMP,
        CL_HALT
    } classe_t;

    localparam logic [2:0] SEL_MOV = 3'b000;
    localparam logic [2:0] SEL_ADD = 3'b001;
    localparam logic [2:0] SEL_SUB = 3'b010;
    localparam logic [2:0] SEL_MUL = 3'b011;
    localparam logic [2:0] SEL_DIV = 3'b100;
    localparam logic [2:0] SEL_AND = 3'b101;
    localparam logic [2:0] SEL_OR  = 3'b110;
    localparam logic [2:0] SEL_NEG = 3'b111;

    localparam logic [1:0] ORIG_R   = 2'b00;
    localparam logic [1:0] ORIG_I   = 2'b01;
    localparam logic [1:0] ORIG_CMP = 2'b10;

    localparam logic [1:0] PC_SEQ    = 2'b00;
    localparam logic [1:0] PC_BRANCH = 2'b01;
    localparam logic [1:0] PC_JUMP   = 2'b10;

endpackage

// File: rtl/unidade_controle_decodificador.sv
// Combinational opcode decoder: maps an opcode to ULA select, ULA mode and instruction class.
module decodificador
    import processador_pkg::*;
#(
    parameter int OPW = 5
) (
    input  logic [OPW-1:0] i_op,
    output logic [2:0]     o_selec,
    output logic [1:0]     o_orig,
    output classe_t        o_classe
);

    always_comb begin
        o_selec  = SEL_MOV;
        o_orig   = ORIG_R;
        o_classe = CL_NOP;
        case (i_op)
            OP_MOV:  begin o_selec = SEL_MOV; o_classe = CL_ALU; end
            OP_ADD:  begin o_selec = SEL_ADD; o_classe = CL_ALU; end
            OP_SUB:  begin o_selec = SEL_SUB; o_classe = CL_ALU; end
            OP_MUL:  begin o_selec = SEL_MUL; o_classe = CL_ALU; end
            OP_DIV:  begin o_selec = SEL_DIV; o_classe = CL_ALU; end
            OP_AND:  begin o_selec = SEL_AND; o_classe = CL_ALU; end
            OP_OR:   begin o_selec = SEL_OR;  o_classe = CL_ALU; end
            OP_NEG:  begin o_selec = SEL_NEG; o_classe = CL_ALU; end
            OP_ADDI: begin o_selec = SEL_ADD; o_orig = ORIG_I;   o_classe = CL_ALU; end
            OP_SUBI: begin o_selec = SEL_SUB; o_orig = ORIG_I;   o_classe = CL_ALU; end
            OP_BLT:  begin o_selec = SEL_ADD; o_orig = ORIG_CMP; o_classe = CL_CMP; end
            OP_BGT:  begin o_selec = SEL_SUB; o_orig = ORIG_CMP; o_classe = CL_CMP; end
            OP_JMP:  o_classe = CL_JMP;
            OP_HALT: o_classe = CL_HALT;
            default: o_classe = CL_NOP;
        endcase
    end

endmodule

// File: rtl/unidade_controle.sv
// Multi-cycle control FSM driving the ULA and PC/IR/register-file enables; counts retired
// instructions and halts on HALT or on an instruction-fetch timeout.
module unidade_controle
    import processador_pkg::*;
#(
    parameter int OPW           = 5,
    parameter int CNTW          = 32,
    parameter int FETCH_TIMEOUT = 15
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [31:0]     instr,
    input  logic            imem_ready,
    input  logic            zero,
    input  logic            negativo,
    output logic            ir_we,
    output logic            pc_we,
    output logic [1:0]      pc_src,
    output logic            reg_we,
    output logic [2:0]      selec,
    output logic [1:0]      origULA,
    output logic            halted,
    output logic            erro,
    output logic [CNTW-1:0] retired
);

    localparam int TW = $clog2(FETCH_TIMEOUT + 1);

    estado_t         r_estado;
    logic [OPW-1:0]  r_op;
    logic            r_flag;
    logic [TW-1:0]   r_timer;
    logic [CNTW-1:0] r_retired;
    logic            r_erro;

    estado_t         w_prox;
    logic [TW-1:0]   w_timer_prox;
    logic            w_fault;
    logic            w_retire;
    logic            w_ir_we;
    logic            w_pc_we;
    logic [1:0]      w_pc_src;
    logic            w_reg_we;
    logic [2:0]      w_selec;
    logic [1:0]      w_orig;

    logic [OPW-1:0]  w_op_instr;
    logic [OPW-1:0]  w_op_dec;
    logic [2:0]      w_dec_selec;
    logic [1:0]      w_dec_orig;
    classe_t         w_dec_classe;
    logic            w_unused;

    assign w_op_instr = instr[31 -: OPW];
    // In DECODE the opcode is still in the IR; afterwards it comes from the latched copy.
    assign w_op_dec   = (r_estado == DECODE) ? w_op_instr : r_op;
    // zero is reserved for future branch types; only the opcode field of instr is used here.
    assign w_unused   = ^{zero, instr[31-OPW:0]};

    decodificador #(
        .OPW (OPW)
    ) u_decodificador (
        .i_op     (w_op_dec),
        .o_selec  (w_dec_selec),
        .o_orig   (w_dec_orig),
        .o_classe (w_dec_classe)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_estado <= FETCH;
        end else begin
            r_estado <= w_prox;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_op      <= '0;
            r_flag    <= 1'b0;
            r_timer   <= '0;
            r_retired <= '0;
            r_erro    <= 1'b0;
        end else begin
            if (r_estado == DECODE)  r_op   <= w_op_instr;
            if (r_estado == EXECUTE) r_flag <= negativo;
            r_timer <= w_timer_prox;
            if (w_fault)  r_erro    <= 1'b1;
            if (w_retire) r_retired <= r_retired + 1'b1;
        end
    end

    always_comb begin
        w_prox       = r_estado;
        w_timer_prox = r_timer;
        w_fault      = 1'b0;
        w_retire     = 1'b0;
        w_ir_we      = 1'b0;
        w_pc_we      = 1'b0;
        w_pc_src     = PC_SEQ;
        w_reg_we     = 1'b0;
        w_selec      = SEL_MOV;
        w_orig       = ORIG_R;
        case (r_estado)
            FETCH: begin
                if (imem_ready) begin
                    w_ir_we      = 1'b1;
                    w_timer_prox = '0;
                    w_prox       = DECODE;
                end else begin
                    w_timer_prox = r_timer + 1'b1;
                    // The low cycle that brings the wait count up to the limit is the fault cycle.
                    if (r_timer == TW'(FETCH_TIMEOUT - 1)) begin
                        w_fault = 1'b1;
                        w_prox  = HALT;
                    end
                end
            end
            DECODE: begin
                case (w_dec_classe)
                    CL_ALU, CL_CMP: w_prox = EXECUTE;
                    CL_HALT:        w_prox = HALT;
                    default:        w_prox = BRANCH;
                endcase
            end
            EXECUTE: begin
                w_selec = w_dec_selec;
                w_orig  = w_dec_orig;
                w_prox  = (w_dec_classe == CL_CMP) ? BRANCH : WRITEBACK;
            end
            WRITEBACK: begin
                w_reg_we = 1'b1;
                w_pc_we  = 1'b1;
                w_pc_src = PC_SEQ;
                w_retire = 1'b1;
                w_prox   = FETCH;
            end
            BRANCH: begin
                w_pc_we  = 1'b1;
                w_retire = 1'b1;
                if (w_dec_classe == CL_JMP) begin
                    w_pc_src = PC_JUMP;
                end else if (w_dec_classe == CL_CMP && r_flag) begin
                    w_pc_src = PC_BRANCH;
                end
                w_prox = FETCH;
            end
            HALT: begin
                w_prox = HALT;
            end
            default: begin
                w_prox = FETCH;
            end
        endcase
    end

    // ir_we is the only output that looks at an input, so it is masked while reset is held.
    assign ir_we   = w_ir_we & ~rst;
    assign pc_we   = w_pc_we;
    assign pc_src  = w_pc_src;
    assign reg_we  = w_reg_we;
    assign selec   = w_selec;
    assign origULA = w_orig;
    assign halted  = (r_estado == HALT);
    assign erro    = r_erro;
    assign retired = r_retired;

endmodule
